// File: rtl/ducq_sched.sv
`default_nettype none
// ============================================================================
//  Module   : ducq_sched
//  Purpose  : Sequencing controller for the quadrature DUC core and phase
//             accumulator. Feeds one IQ sample at a time to the core, forwards
//             its result, and applies frequency-word updates only between
//             bursts so the phase never steps mid-burst.
//  Revision : 1.0  initial release
// ============================================================================
module ducq_sched #(
  parameter int DW      = 14,  // IQ sample width, signed [2:-11]
  parameter int FW      = 30,  // frequency word / phase accumulator width
  parameter int TIMEOUT = 64,  // cycles from duc_start to abort (>=2)
  parameter int CNT_W   = 16   // per-burst sample counter width
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [DW-1:0]    s_x_i,
  input  logic [DW-1:0]    s_y_i,
  input  logic             s_last_i,
  input  logic             cfg_wr_i,
  input  logic [FW-1:0]    cfg_freq_i,
  output logic             cfg_pending_o,
  output logic [FW-1:0]    duc_freq_o,
  output logic             duc_start_o,
  output logic [DW-1:0]    duc_x_o,
  output logic [DW-1:0]    duc_y_o,
  input  logic             duc_done_i,
  input  logic [DW-1:0]    duc_ox_i,
  input  logic [DW-1:0]    duc_oy_i,
  output logic             m_valid_o,
  output logic [DW-1:0]    m_x_o,
  output logic [DW-1:0]    m_y_o,
  output logic             m_last_o,
  output logic [CNT_W-1:0] burst_cnt_o,
  output logic             err_timeout_o
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t           state_q;
  logic             in_burst_q;
  logic             cfg_pending_q;
  logic [FW-1:0]    shadow_q;
  logic [FW-1:0]    duc_freq_q;
  logic             duc_start_q;
  logic [DW-1:0]    duc_x_q;
  logic [DW-1:0]    duc_y_q;
  logic             tag_q;
  logic [TW-1:0]    tcnt_q;
  logic             m_valid_q;
  logic [DW-1:0]    m_x_q;
  logic [DW-1:0]    m_y_q;
  logic             m_last_q;
  logic [CNT_W-1:0] burst_cnt_q;
  logic             err_q;

  logic             apply_d;
  logic             accept_d;
  logic [CNT_W-1:0] burst_cnt_d;

  // Apply a pending frequency word only while idle and outside a burst; it
  // takes priority over accepting a new sample, which is why s_ready drops.
  assign apply_d     = (state_q == ST_IDLE) & cfg_pending_q & ~in_burst_q;
  assign s_ready_o   = ~reset_i & (state_q == ST_IDLE) & enable_i
                     & ~(cfg_pending_q & ~in_burst_q);
  assign accept_d    = s_valid_i & s_ready_o;
  assign burst_cnt_d = (&burst_cnt_q) ? burst_cnt_q : burst_cnt_q + 1'b1;

  // Sequencing FSM with all outputs registered; the timeout is decided in the
  // TIMEOUT-th cycle after duc_start when no done has been seen.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      in_burst_q    <= 1'b0;
      cfg_pending_q <= 1'b0;
      shadow_q      <= '0;
      duc_freq_q    <= '0;
      duc_start_q   <= 1'b0;
      duc_x_q       <= '0;
      duc_y_q       <= '0;
      tag_q         <= 1'b0;
      tcnt_q        <= '0;
      m_valid_q     <= 1'b0;
      m_x_q         <= '0;
      m_y_q         <= '0;
      m_last_q      <= 1'b0;
      burst_cnt_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      duc_start_q <= 1'b0;
      // A new write always lands in the shadow; if it coincides with an
      // apply, the apply below still sees the old shadow value.
      if (cfg_wr_i) begin
        shadow_q      <= cfg_freq_i;
        cfg_pending_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (apply_d) begin
            duc_freq_q <= shadow_q;
            if (!cfg_wr_i) cfg_pending_q <= 1'b0;
          end else if (accept_d) begin
            duc_x_q     <= s_x_i;
            duc_y_q     <= s_y_i;
            tag_q       <= s_last_i;
            in_burst_q  <= 1'b1;
            duc_start_q <= 1'b1;
            state_q     <= ST_START;
          end
        end
        ST_START: begin
          tcnt_q  <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (duc_done_i) begin
            m_valid_q   <= 1'b1;
            m_x_q       <= duc_ox_i;
            m_y_q       <= duc_oy_i;
            m_last_q    <= tag_q;
            burst_cnt_q <= tag_q ? '0 : burst_cnt_d;
            if (tag_q) in_burst_q <= 1'b0;
            state_q     <= ST_IDLE;
          end else if (tcnt_q == TO_LAST) begin
            err_q       <= 1'b1;
            in_burst_q  <= 1'b0;
            burst_cnt_q <= '0;
            state_q     <= ST_IDLE;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cfg_pending_o = cfg_pending_q;
  assign duc_freq_o    = duc_freq_q;
  assign duc_start_o   = duc_start_q;
  assign duc_x_o       = duc_x_q;
  assign duc_y_o       = duc_y_q;
  assign m_valid_o     = m_valid_q;
  assign m_x_o         = m_x_q;
  assign m_y_o         = m_y_q;
  assign m_last_o      = m_last_q;
  assign burst_cnt_o   = burst_cnt_q;
  assign err_timeout_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ducq_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ducq_sched
//  Purpose  : Self-checking bench for ducq_sched. A cycle-stamped transaction
//             model predicts every output each cycle; literal checks pin the
//             model at key points of each scenario.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ducq_sched;
  localparam int DW = 14;
  localparam int FW = 30;
  localparam int TO = 64;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, sv, sl, cfg_wr, core_done, spur_done, duc_done;
  logic [DW-1:0] sx, sy, ox, oy;
  logic [FW-1:0] cfg_freq;
  logic          s_ready, cfg_pending, duc_start, m_valid, m_last, err_to;
  logic [FW-1:0] duc_freq;
  logic [DW-1:0] duc_x, duc_y, m_x, m_y;
  logic [CW-1:0] burst_cnt;

  assign duc_done = core_done | spur_done;

  ducq_sched #(.DW(DW), .FW(FW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i(clk), .reset_i(rst), .enable_i(en),
    .s_valid_i(sv), .s_ready_o(s_ready), .s_x_i(sx), .s_y_i(sy), .s_last_i(sl),
    .cfg_wr_i(cfg_wr), .cfg_freq_i(cfg_freq), .cfg_pending_o(cfg_pending),
    .duc_freq_o(duc_freq), .duc_start_o(duc_start), .duc_x_o(duc_x), .duc_y_o(duc_y),
    .duc_done_i(duc_done), .duc_ox_i(ox), .duc_oy_i(oy),
    .m_valid_o(m_valid), .m_x_o(m_x), .m_y_o(m_y), .m_last_o(m_last),
    .burst_cnt_o(burst_cnt), .err_timeout_o(err_to)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- core emulator: done a fixed number of cycles after start
  int            core_lat = 12;   // cycles from duc_start to duc_done; 0 = never
  int            ccnt = 0;
  logic          st_seen = 1'b0;
  logic [DW-1:0] cx = '0, cy = '0;

  always @(negedge clk) begin
    st_seen = duc_start;
    if (duc_start) begin cx = duc_x; cy = duc_y; end
  end

  initial begin
    core_done = 1'b0; ox = '0; oy = '0;
    forever begin
      @(posedge clk); #1;
      core_done = 1'b0;
      ox = ~cx; oy = ~cy;
      if (ccnt > 0) begin
        ccnt--;
        if (ccnt == 0) begin
          core_done = 1'b1;
          ox = cx + 14'd5;
          oy = cy - 14'd3;
        end
      end
      if (st_seen && core_lat > 1) ccnt = core_lat - 1;
    end
  end

  // ---------------- transaction model (cycle-stamped)
  int            cyc = 0;
  bit            e_busy = 0;       // a sample has been accepted and not finished
  int            e_start = 0;      // cycle in which duc_start must be seen
  bit            e_inb = 0, e_pend = 0, e_tag = 0, e_err = 0, e_mv = 0, e_ml = 0;
  logic [FW-1:0] e_shadow = '0, e_freq = '0;
  logic [DW-1:0] e_hx = '0, e_hy = '0, e_mx = '0, e_my = '0;
  logic [CW-1:0] e_cnt = '0;
  int            n_start = 0, n_mv = 0, n_ml = 0;

  always @(negedge clk) begin : p_cmp
    bit ready_e, apply_e;
    cyc++;
    if (rst) begin
      chk("s_ready_in_reset", 32'(s_ready), 32'd0);
      e_busy = 0; e_inb = 0; e_pend = 0; e_tag = 0; e_err = 0; e_mv = 0; e_ml = 0;
      e_shadow = '0; e_freq = '0; e_hx = '0; e_hy = '0; e_mx = '0; e_my = '0; e_cnt = '0;
    end else begin
      apply_e = !e_busy && e_pend && !e_inb;
      ready_e = !e_busy && en && !(e_pend && !e_inb);
      chk("s_ready",     32'(s_ready),     32'(ready_e));
      chk("duc_start",   32'(duc_start),   32'(e_busy && cyc == e_start));
      chk("cfg_pending", 32'(cfg_pending), 32'(e_pend));
      chk("duc_freq",    32'(duc_freq),    32'(e_freq));
      chk("duc_x",       32'(duc_x),       32'(e_hx));
      chk("duc_y",       32'(duc_y),       32'(e_hy));
      chk("m_valid",     32'(m_valid),     32'(e_mv));
      chk("m_last",      32'(m_last),      32'(e_ml));
      chk("m_x",         32'(m_x),         32'(e_mx));
      chk("m_y",         32'(m_y),         32'(e_my));
      chk("burst_cnt",   32'(burst_cnt),   32'(e_cnt));
      chk("err_timeout", 32'(err_to),      32'(e_err));
      if (duc_start) n_start++;
      if (m_valid) n_mv++;
      if (m_valid && m_last) n_ml++;
      // what the rules say happens at the coming edge
      e_mv = 0; e_ml = 0;
      if (e_busy && cyc > e_start) begin
        if (duc_done) begin
          e_mv = 1; e_ml = e_tag; e_mx = ox; e_my = oy;
          e_cnt = e_tag ? '0 : ((e_cnt == '1) ? e_cnt : e_cnt + 1'b1);
          if (e_tag) e_inb = 0;
          e_busy = 0;
        end else if (cyc == e_start + TO) begin
          e_err = 1; e_inb = 0; e_cnt = '0; e_busy = 0;
        end
      end else if (apply_e) begin
        e_freq = e_shadow; e_pend = 0;
      end else if (ready_e && sv) begin
        e_busy = 1; e_start = cyc + 1; e_hx = sx; e_hy = sy; e_tag = sl; e_inb = 1;
      end
      if (cfg_wr) begin e_shadow = cfg_freq; e_pend = 1; end
    end
  end

  // ---------------- stimulus helpers
  task automatic send(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic last);
    bit got = 0;
    @(posedge clk); #1;
    sv = 1'b1; sx = x; sy = y; sl = last;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (s_ready) begin got = 1; break; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL send_handshake: got s_ready=0 for 300 cycles expected 1");
    end
    @(posedge clk); #1;
    sv = 1'b0; sl = 1'b0;
  endtask

  task automatic cfg(input logic [FW-1:0] w);
    @(posedge clk); #1; cfg_wr = 1'b1; cfg_freq = w;
    @(posedge clk); #1; cfg_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int b_st, b_mv, b_ml;

  initial begin
    rst = 1'b1; en = 1'b1; sv = 1'b0; sl = 1'b0; sx = '0; sy = '0;
    cfg_wr = 1'b0; cfg_freq = '0; spur_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_freq", 32'(duc_freq), 32'd0);
    chk("rst_cnt", 32'(burst_cnt), 32'd0);
    chk("rst_pend", 32'(cfg_pending), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd1);

    // 1) idle frequency apply
    @(posedge clk); #1; cfg_wr = 1'b1; cfg_freq = 30'h0100_0000;
    @(posedge clk); #1; cfg_wr = 1'b0;
    @(negedge clk);
    chk("t1_pend_set", 32'(cfg_pending), 32'd1);
    chk("t1_ready_low", 32'(s_ready), 32'd0);
    @(negedge clk);
    chk("t1_pend_clr", 32'(cfg_pending), 32'd0);
    chk("t1_freq", 32'(duc_freq), 32'h0100_0000);

    // 2) four-sample burst, core latency 12
    core_lat = 12;
    b_st = n_start; b_mv = n_mv; b_ml = n_ml;
    send(14'd100, -14'sd50, 1'b0);
    send(14'd200, 14'd7, 1'b0);
    send(-14'sd300, 14'd1000, 1'b0);
    send(14'd400, -14'sd1, 1'b1);
    idle(20);
    chk("t2_starts", 32'(n_start - b_st), 32'd4);
    chk("t2_mvalid", 32'(n_mv - b_mv), 32'd4);
    chk("t2_mlast", 32'(n_ml - b_ml), 32'd1);
    chk("t2_m_x", 32'(m_x), 32'(14'd405));

    // 3) frequency write mid-burst is held off until the burst ends
    send(14'd11, 14'd12, 1'b0);
    send(14'd21, 14'd22, 1'b0);
    cfg(30'h0200_0000);
    @(negedge clk);
    chk("t3_freq_held", 32'(duc_freq), 32'h0100_0000);
    chk("t3_pend", 32'(cfg_pending), 32'd1);
    send(14'd31, 14'd32, 1'b0);
    send(14'd41, 14'd42, 1'b1);
    send(14'd51, 14'd52, 1'b0);
    send(14'd61, 14'd62, 1'b1);
    idle(20);
    chk("t3_freq_new", 32'(duc_freq), 32'h0200_0000);

    // 4) core never answers -> timeout, then recovery
    core_lat = 0;
    b_mv = n_mv;
    send(14'd77, 14'd88, 1'b0);
    idle(75);
    @(negedge clk);
    chk("t4_err", 32'(err_to), 32'd1);
    chk("t4_no_mv", 32'(n_mv - b_mv), 32'd0);
    chk("t4_ready", 32'(s_ready), 32'd1);
    core_lat = 6;
    send(14'd99, 14'd98, 1'b1);
    idle(12);
    chk("t4_recover", 32'(n_mv - b_mv), 32'd1);

    // 5) last write wins; write coincident with apply
    send(14'd1, 14'd2, 1'b0);
    cfg(30'h0AAA_AAAA);
    cfg(30'h0BBB_BBBB);
    send(14'd3, 14'd4, 1'b1);
    idle(12);
    chk("t5_last_wins", 32'(duc_freq), 32'h0BBB_BBBB);
    @(posedge clk); #1; cfg_wr = 1'b1; cfg_freq = 30'h0CCC_CCCC;
    @(posedge clk); #1; cfg_freq = 30'h0DDD_DDDD;
    @(posedge clk); #1; cfg_wr = 1'b0;
    @(negedge clk);
    chk("t5_old_applied", 32'(duc_freq), 32'h0CCC_CCCC);
    chk("t5_pend_kept", 32'(cfg_pending), 32'd1);
    @(negedge clk);
    chk("t5_new_applied", 32'(duc_freq), 32'h0DDD_DDDD);
    chk("t5_pend_clr", 32'(cfg_pending), 32'd0);

    // enable dropped mid-burst: in-flight sample finishes, nothing new accepted
    core_lat = 8;
    b_mv = n_mv;
    send(14'd5, 14'd6, 1'b0);
    @(posedge clk); #1; en = 1'b0; sv = 1'b1; sx = 14'd9; sy = 14'd9;
    idle(20);
    sv = 1'b0;
    chk("en_one_done", 32'(n_mv - b_mv), 32'd1);
    chk("en_cnt", 32'(burst_cnt), 32'd1);
    en = 1'b1;
    send(14'd7, 14'd8, 1'b1);
    idle(12);
    chk("en_cnt_end", 32'(burst_cnt), 32'd0);

    // 6) reset during WAIT drops the in-flight result
    core_lat = 12;
    send(14'd123, 14'd321, 1'b0);
    idle(4);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    b_mv = n_mv;
    chk("t6_freq", 32'(duc_freq), 32'd0);
    chk("t6_err", 32'(err_to), 32'd0);
    chk("t6_duc_x", 32'(duc_x), 32'd0);
    chk("t6_mvalid", 32'(m_valid), 32'd0);
    idle(20);
    @(posedge clk); #1; spur_done = 1'b1;
    @(posedge clk); #1; spur_done = 1'b0;
    idle(3);
    chk("t6_late_done", 32'(n_mv - b_mv), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
